// File: rtl/m_cp0_unit.sv
// Coprocessor-0 for the M stage: SR/Cause/EPC/PRId storage, mtc0/mfc0/eret
// traffic, and interrupt/exception arbitration producing the flush request.
module m_cp0_unit #(
  parameter logic [31:0] PRID_VALUE = 32'h2022_0707,
  parameter logic [31:0] EPC_RESET  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  A1,
  input  logic [4:0]  A2,
  input  logic [31:0] DIn,
  input  logic        WE,
  input  logic [31:0] PC,
  input  logic        BDIn,
  input  logic [4:0]  ExcCodeIn,
  input  logic [5:0]  HWInt,
  input  logic        EXLClr,
  output logic [31:0] DOut,
  output logic [31:0] EPCOut,
  output logic        Req
);

  logic [5:0]  sr_im_r;
  logic        sr_exl_r;
  logic        sr_ie_r;
  logic        cause_bd_r;
  logic [5:0]  cause_ip_r;
  logic [4:0]  cause_exc_r;
  logic [31:0] epc_r;

  logic        int_req_s;
  logic        exc_req_s;
  logic        req_s;
  logic [31:0] sr_val_s;
  logic [31:0] cause_val_s;

  assign sr_val_s    = {16'h0000, sr_im_r, 8'h00, sr_exl_r, sr_ie_r};
  assign cause_val_s = {cause_bd_r, 15'h0000, cause_ip_r, 3'b000, cause_exc_r, 2'b00};

  // Request arbitration; EXL masks both interrupts and exceptions.
  always_comb begin
    int_req_s = (|(HWInt & sr_im_r)) & sr_ie_r & ~sr_exl_r;
    exc_req_s = (ExcCodeIn != 5'd0) & ~sr_exl_r;
    req_s     = int_req_s | exc_req_s;
  end

  assign Req = req_s;

  // mfc0 read mux, showing pre-edge register contents.
  always_comb begin
    DOut = 32'h0000_0000;
    case (A1)
      5'd12:   DOut = sr_val_s;
      5'd13:   DOut = cause_val_s;
      5'd14:   DOut = epc_r;
      5'd15:   DOut = PRID_VALUE;
      default: DOut = 32'h0000_0000;
    endcase
  end

  // EPC bypass so an eret right behind an mtc0 EPC returns to the new target.
  always_comb begin
    EPCOut = epc_r;
    if (WE && !req_s && (A2 == 5'd14)) begin
      EPCOut = DIn;
    end else begin
      EPCOut = epc_r;
    end
  end

  // CP0 state update; a taken request flushes any mtc0/eret in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      sr_im_r     <= 6'd0;
      sr_exl_r    <= 1'b0;
      sr_ie_r     <= 1'b0;
      cause_bd_r  <= 1'b0;
      cause_ip_r  <= 6'd0;
      cause_exc_r <= 5'd0;
      epc_r       <= EPC_RESET;
    end else begin
      cause_ip_r <= HWInt;
      if (req_s) begin
        sr_exl_r    <= 1'b1;
        cause_bd_r  <= BDIn;
        cause_exc_r <= int_req_s ? 5'd0 : ExcCodeIn;
        epc_r       <= BDIn ? (PC - 32'd4) : PC;
      end else begin
        if (WE) begin
          case (A2)
            5'd12: begin
              sr_im_r  <= DIn[15:10];
              sr_exl_r <= DIn[1];
              sr_ie_r  <= DIn[0];
            end
            5'd14:   epc_r <= DIn;
            default: ;
          endcase
        end
        // eret wins over an EXL bit written by the same-cycle mtc0.
        if (EXLClr) begin
          sr_exl_r <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_m_cp0_unit.sv
// Table-driven bench for m_cp0_unit: each record drives one cycle; expected
// combinational outputs go through a scoreboard queue before comparison.
module tb_m_cp0_unit;

  logic        clk;
  logic        reset;
  logic [4:0]  A1, A2, ExcCodeIn;
  logic [31:0] DIn, PC;
  logic        WE, BDIn, EXLClr;
  logic [5:0]  HWInt;
  logic [31:0] DOut, EPCOut;
  logic        Req;

  m_cp0_unit dut (
    .clk(clk), .reset(reset), .A1(A1), .A2(A2), .DIn(DIn), .WE(WE), .PC(PC),
    .BDIn(BDIn), .ExcCodeIn(ExcCodeIn), .HWInt(HWInt), .EXLClr(EXLClr),
    .DOut(DOut), .EPCOut(EPCOut), .Req(Req)
  );

  typedef struct {
    logic        rst;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [31:0] din;
    logic        we;
    logic [31:0] pc;
    logic        bd;
    logic [4:0]  exc;
    logic [5:0]  hw;
    logic        eclr;
    logic        e_req;
    logic [31:0] e_dout;
    logic [31:0] e_epc;
  } vec_t;

  typedef struct {
    logic        req;
    logic [31:0] dout;
    logic [31:0] epc;
    int          idx;
  } exp_t;

  vec_t tbl[$];
  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(logic rst, logic [4:0] a1, logic [4:0] a2, logic [31:0] din,
                              logic we, logic [31:0] pc, logic bd, logic [4:0] exc,
                              logic [5:0] hw, logic eclr, logic e_req,
                              logic [31:0] e_dout, logic [31:0] e_epc);
    vec_t v;
    v.rst = rst; v.a1 = a1; v.a2 = a2; v.din = din; v.we = we; v.pc = pc;
    v.bd = bd; v.exc = exc; v.hw = hw; v.eclr = eclr;
    v.e_req = e_req; v.e_dout = e_dout; v.e_epc = e_epc;
    return v;
  endfunction

  task automatic apply(input vec_t v, input int idx);
    exp_t e;
    exp_t got;
    @(negedge clk);
    reset = v.rst; A1 = v.a1; A2 = v.a2; DIn = v.din; WE = v.we; PC = v.pc;
    BDIn = v.bd; ExcCodeIn = v.exc; HWInt = v.hw; EXLClr = v.eclr;
    e.req = v.e_req; e.dout = v.e_dout; e.epc = v.e_epc; e.idx = idx;
    sb_q.push_back(e);
    #2;
    got = sb_q.pop_front();
    n_checks++;
    if (Req !== got.req) begin
      n_fail++;
      $display("FAIL req step %0d: got %b expected %b", got.idx, Req, got.req);
    end
    n_checks++;
    if (DOut !== got.dout) begin
      n_fail++;
      $display("FAIL dout step %0d: got %h expected %h", got.idx, DOut, got.dout);
    end
    n_checks++;
    if (EPCOut !== got.epc) begin
      n_fail++;
      $display("FAIL epcout step %0d: got %h expected %h", got.idx, EPCOut, got.epc);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; A1 = 5'd0; A2 = 5'd0; DIn = 32'd0; WE = 1'b0; PC = 32'd0;
    BDIn = 1'b0; ExcCodeIn = 5'd0; HWInt = 6'd0; EXLClr = 1'b0;
    @(negedge clk);
    @(negedge clk);

    //           rst   a1     a2     din            we    pc            bd    exc    hw        eclr  req   dout           epcout
    tbl.push_back(mk(1'b0, 5'd12, 5'd0, 32'h0,        1'b0, 32'h0,      1'b0, 5'd0,  6'h00,    1'b0, 1'b0, 32'h0,         32'h0));
    tbl.push_back(mk(1'b0, 5'd13, 5'd0, 32'h0,        1'b0, 32'h0,      1'b0, 5'd0,  6'h00,    1'b0, 1'b0, 32'h0,         32'h0));
    tbl.push_back(mk(1'b0, 5'd14, 5'd0, 32'h0,        1'b0, 32'h0,      1'b0, 5'd0,  6'h00,    1'b0, 1'b0, 32'h0,         32'h0));
    tbl.push_back(mk(1'b0, 5'd15, 5'd0, 32'h0,        1'b0, 32'h0,      1'b0, 5'd0,  6'h00,    1'b0, 1'b0, 32'h2022_0707, 32'h0));
    tbl.push_back(mk(1'b0, 5'd12, 5'd12, 32'hFFFF_FFFF, 1'b1, 32'h0,    1'b0, 5'd0,  6'h00,    1'b0, 1'b0, 32'h0,         32'h0));
    tbl.push_back(mk(1'b0, 5'd12, 5'd0, 32'h0,        1'b0, 32'h0,      1'b0, 5'd0,  6'b000100, 1'b1, 1'b0, 32'h0000_FC03, 32'h0));
    tbl.push_back(mk(1'b0, 5'd12, 5'd0, 32'h0,        1'b0, 32'h1000,   1'b0, 5'd0,  6'b000100, 1'b0, 1'b1, 32'h0000_FC01, 32'h0));
    tbl.push_back(mk(1'b0, 5'd13, 5'd0, 32'h0,        1'b0, 32'h0,      1'b0, 5'd0,  6'b000100, 1'b0, 1'b0, 32'h0000_1000, 32'h1000));
    tbl.push_back(mk(1'b0, 5'd12, 5'd0, 32'h0,        1'b0, 32'h0,      1'b0, 5'd0,  6'h00,    1'b0, 1'b0, 32'h0000_FC03, 32'h1000));
    tbl.push_back(mk(1'b0, 5'd14, 5'd0, 32'h0,        1'b0, 32'h0,      1'b0, 5'd0,  6'h00,    1'b1, 1'b0, 32'h0000_1000, 32'h1000));
    tbl.push_back(mk(1'b0, 5'd12, 5'd12, 32'h0,       1'b1, 32'h0,      1'b0, 5'd0,  6'h00,    1'b0, 1'b0, 32'h0000_FC01, 32'h1000));
    tbl.push_back(mk(1'b0, 5'd12, 5'd0, 32'h0,        1'b0, 32'h3010,   1'b1, 5'd4,  6'h00,    1'b0, 1'b1, 32'h0,         32'h1000));
    tbl.push_back(mk(1'b0, 5'd14, 5'd0, 32'h0,        1'b0, 32'h0,      1'b0, 5'd0,  6'h00,    1'b0, 1'b0, 32'h0000_300C, 32'h300C));
    tbl.push_back(mk(1'b0, 5'd13, 5'd0, 32'h0,        1'b0, 32'h0,      1'b0, 5'd0,  6'h00,    1'b0, 1'b0, 32'h8000_0010, 32'h300C));
    tbl.push_back(mk(1'b0, 5'd12, 5'd0, 32'h0,        1'b0, 32'h0,      1'b0, 5'd0,  6'h00,    1'b0, 1'b0, 32'h0000_0002, 32'h300C));
    tbl.push_back(mk(1'b0, 5'd13, 5'd0, 32'h0,        1'b0, 32'h5000,   1'b0, 5'd12, 6'h3F,    1'b0, 1'b0, 32'h8000_0010, 32'h300C));
    tbl.push_back(mk(1'b0, 5'd13, 5'd0, 32'h0,        1'b0, 32'h5000,   1'b0, 5'd12, 6'h3F,    1'b0, 1'b0, 32'h8000_FC10, 32'h300C));
    tbl.push_back(mk(1'b0, 5'd14, 5'd0, 32'h0,        1'b0, 32'h0,      1'b0, 5'd0,  6'h00,    1'b0, 1'b0, 32'h0000_300C, 32'h300C));
    tbl.push_back(mk(1'b0, 5'd14, 5'd14, 32'h3400,    1'b1, 32'h0,      1'b0, 5'd0,  6'h00,    1'b0, 1'b0, 32'h0000_300C, 32'h3400));
    tbl.push_back(mk(1'b0, 5'd14, 5'd0, 32'h0,        1'b0, 32'h0,      1'b0, 5'd0,  6'h00,    1'b1, 1'b0, 32'h0000_3400, 32'h3400));
    tbl.push_back(mk(1'b0, 5'd12, 5'd0, 32'h0,        1'b0, 32'h0,      1'b0, 5'd0,  6'h00,    1'b0, 1'b0, 32'h0,         32'h3400));
    tbl.push_back(mk(1'b0, 5'd14, 5'd14, 32'h1234,    1'b1, 32'h2000,   1'b0, 5'd10, 6'h00,    1'b0, 1'b1, 32'h0000_3400, 32'h3400));
    tbl.push_back(mk(1'b0, 5'd14, 5'd0, 32'h0,        1'b0, 32'h0,      1'b0, 5'd0,  6'h00,    1'b0, 1'b0, 32'h0000_2000, 32'h2000));
    tbl.push_back(mk(1'b0, 5'd13, 5'd0, 32'h0,        1'b0, 32'h0,      1'b0, 5'd0,  6'h00,    1'b0, 1'b0, 32'h0000_0028, 32'h2000));
    tbl.push_back(mk(1'b1, 5'd12, 5'd0, 32'h0,        1'b0, 32'h0,      1'b0, 5'd0,  6'h00,    1'b0, 1'b0, 32'h0000_0002, 32'h2000));
    tbl.push_back(mk(1'b0, 5'd12, 5'd0, 32'h0,        1'b0, 32'h0,      1'b0, 5'd0,  6'h00,    1'b0, 1'b0, 32'h0,         32'h0));
    tbl.push_back(mk(1'b0, 5'd13, 5'd0, 32'h0,        1'b0, 32'h0,      1'b0, 5'd0,  6'h00,    1'b0, 1'b0, 32'h0,         32'h0));
    tbl.push_back(mk(1'b0, 5'd12, 5'd12, 32'h3,       1'b1, 32'h0,      1'b0, 5'd0,  6'h00,    1'b1, 1'b0, 32'h0,         32'h0));
    tbl.push_back(mk(1'b0, 5'd12, 5'd0, 32'h0,        1'b0, 32'h0,      1'b0, 5'd0,  6'h00,    1'b0, 1'b0, 32'h0000_0001, 32'h0));
    tbl.push_back(mk(1'b0, 5'd12, 5'd12, 32'h401,     1'b1, 32'h0,      1'b0, 5'd0,  6'h00,    1'b0, 1'b0, 32'h0000_0001, 32'h0));
    tbl.push_back(mk(1'b0, 5'd13, 5'd0, 32'h0,        1'b0, 32'h44,     1'b1, 5'd8,  6'h01,    1'b0, 1'b1, 32'h0,         32'h0));
    tbl.push_back(mk(1'b0, 5'd13, 5'd0, 32'h0,        1'b0, 32'h0,      1'b0, 5'd0,  6'h00,    1'b0, 1'b0, 32'h8000_0400, 32'h40));
    tbl.push_back(mk(1'b0, 5'd14, 5'd0, 32'h0,        1'b0, 32'h0,      1'b0, 5'd0,  6'h00,    1'b0, 1'b0, 32'h0000_0040, 32'h40));

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i], i);
    end

    // EPC wraparound: exception in a delay slot at PC 0 records 0xFFFF_FFFC.
    apply(mk(1'b0, 5'd12, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0, 5'd0, 6'h00, 1'b1, 1'b0, 32'h0000_0403, 32'h40), 100);
    apply(mk(1'b0, 5'd12, 5'd0, 32'h0, 1'b0, 32'h0, 1'b1, 5'd1, 6'h00, 1'b0, 1'b1, 32'h0000_0401, 32'h40), 101);
    apply(mk(1'b0, 5'd14, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0, 5'd0, 6'h00, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'hFFFF_FFFC), 102);

    // Masked interrupt line: IM only enables line 0, so line 5 must not request.
    apply(mk(1'b0, 5'd12, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0, 5'd0, 6'h00, 1'b1, 1'b0, 32'h0000_0403, 32'hFFFF_FFFC), 103);
    apply(mk(1'b0, 5'd12, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0, 5'd0, 6'h20, 1'b0, 1'b0, 32'h0000_0401, 32'hFFFF_FFFC), 104);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
